// File: rtl/spi_ram_pkg.sv
// Shared constants and types for the SPI scratch-RAM arbiter.
// Port pointer encodings, default widths, lock owner states.
package spi_ram_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } lock_e;

endpackage

// File: rtl/ram_sp.sv
// Registered-read single-port RAM, no reset, infers block RAM.
// Ports: clk, we, addr, wdata, rdata (one cycle after addr).
module ram_sp #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter with lock sharing a scratch RAM between SPI (A) and fabric (B).
// Ports: per-port req/we/lock/addr/wdata in, gnt/rdata/rvalid out; lock_a/lock_b debug.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic [DW-1:0] a_rdata,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic [DW-1:0] b_rdata,
  output logic          b_rvalid,
  output logic          lock_a,
  output logic          lock_b
);

  lock_e         state;
  lock_e         state_d;
  logic          rr;
  logic          a_c;
  logic          b_c;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] a_hold;
  logic [DW-1:0] b_hold;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    unique case (state)
      OWN_A: a_gnt = a_req;
      OWN_B: b_gnt = b_req;
      default: begin
        if (a_req && b_req) begin
          // tie goes to the port that was not granted last
          a_gnt = (rr == PORT_B);
          b_gnt = (rr == PORT_A);
        end else begin
          a_gnt = a_req;
          b_gnt = b_req;
        end
      end
    endcase
  end

  assign a_c = a_req & a_gnt;
  assign b_c = b_req & b_gnt;

  always_comb begin
    state_d = state;
    unique case (state)
      OWN_A: begin
        if (!a_lock && (a_c || !a_req)) state_d = NONE;
      end
      OWN_B: begin
        if (!b_lock && (b_c || !b_req)) state_d = NONE;
      end
      default: begin
        if (a_c && a_lock)      state_d = OWN_A;
        else if (b_c && b_lock) state_d = OWN_B;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= NONE;
      rr       <= PORT_B;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_hold   <= '0;
      b_hold   <= '0;
    end else begin
      state    <= state_d;
      if (a_c)      rr <= PORT_A;
      else if (b_c) rr <= PORT_B;
      a_rvalid <= a_c & ~a_we;
      b_rvalid <= b_c & ~b_we;
      if (a_rvalid) a_hold <= ram_rdata;
      if (b_rvalid) b_hold <= ram_rdata;
    end
  end

  // RAM output is shared; each port sees it live on its rvalid cycle
  // and a captured copy afterwards.
  assign a_rdata = a_rvalid ? ram_rdata : a_hold;
  assign b_rdata = b_rvalid ? ram_rdata : b_hold;

  assign ram_we    = (a_c & a_we) | (b_c & b_we);
  assign ram_addr  = a_gnt ? a_addr : b_addr;
  assign ram_wdata = a_gnt ? a_wdata : b_wdata;

  assign lock_a = (state == OWN_A);
  assign lock_b = (state == OWN_B);

  ram_sp #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter.
// Drives on negedge, checks gnt mid-cycle and read results on the next negedge.
module tb_spi_ram_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a_req, a_we, a_lock;
  logic [7:0] a_addr, a_wdata;
  logic       a_gnt, a_rvalid;
  logic [7:0] a_rdata;
  logic       b_req, b_we, b_lock;
  logic [7:0] b_addr, b_wdata;
  logic       b_gnt, b_rvalid;
  logic [7:0] b_rdata;
  logic       lock_a, lock_b;

  int total = 0;
  int bad   = 0;

  spi_ram_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_req   (a_req),
    .a_we    (a_we),
    .a_lock  (a_lock),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .a_gnt   (a_gnt),
    .a_rdata (a_rdata),
    .a_rvalid(a_rvalid),
    .b_req   (b_req),
    .b_we    (b_we),
    .b_lock  (b_lock),
    .b_addr  (b_addr),
    .b_wdata (b_wdata),
    .b_gnt   (b_gnt),
    .b_rdata (b_rdata),
    .b_rvalid(b_rvalid),
    .lock_a  (lock_a),
    .lock_b  (lock_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv_a(input logic r, input logic w, input logic l,
                       input logic [7:0] ad, input logic [7:0] d);
    a_req = r; a_we = w; a_lock = l; a_addr = ad; a_wdata = d;
  endtask

  task automatic drv_b(input logic r, input logic w, input logic l,
                       input logic [7:0] ad, input logic [7:0] d);
    b_req = r; b_we = w; b_lock = l; b_addr = ad; b_wdata = d;
  endtask

  initial begin
    rst_n = 1'b0;
    drv_a(0, 0, 0, 8'h00, 8'h00);
    drv_b(0, 0, 0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    chk("rst_ardata", a_rdata, 0);
    chk("rst_brdata", b_rdata, 0);
    chk("rst_arv", a_rvalid, 0);
    chk("rst_brv", b_rvalid, 0);
    chk("rst_locka", lock_a, 0);
    chk("rst_lockb", lock_b, 0);
    rst_n = 1'b1;

    // write then read back on port A
    @(negedge clk);
    drv_a(1, 1, 0, 8'h10, 8'h5A);
    #1 chk("wr_agnt", a_gnt, 1);
    chk("wr_bgnt", b_gnt, 0);
    @(negedge clk);
    chk("wr_norv", a_rvalid, 0);
    drv_a(1, 0, 0, 8'h10, 8'h00);
    #1 chk("rd_agnt", a_gnt, 1);
    @(negedge clk);
    chk("rd_rv", a_rvalid, 1);
    chk("rd_data", a_rdata, 8'h5A);
    drv_a(0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("rd_pulse", a_rvalid, 0);
    chk("rd_hold", a_rdata, 8'h5A);

    // B write leaves pointer at B so the first tie goes to A
    drv_b(1, 1, 0, 8'h20, 8'h33);
    #1 chk("bwr_gnt", b_gnt, 1);
    @(negedge clk);

    // both read continuously: A,B,A,B,A,B
    drv_a(1, 0, 0, 8'h10, 8'h00);
    drv_b(1, 0, 0, 8'h20, 8'h00);
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_agnt", a_gnt, (i % 2 == 0));
      chk("rr_bgnt", b_gnt, (i % 2 == 1));
      @(negedge clk);
      chk("rr_arv", a_rvalid, (i % 2 == 0));
      chk("rr_brv", b_rvalid, (i % 2 == 1));
      if (i % 2 == 0) chk("rr_adata", a_rdata, 8'h5A);
      else            chk("rr_bdata", b_rdata, 8'h33);
    end

    // locked burst write by A while B waits on 0x02
    drv_b(1, 0, 0, 8'h02, 8'h00);
    for (int i = 0; i < 4; i++) begin
      drv_a(1, 1, (i < 3), 8'(i), 8'(8'hA0 + i));
      #1 chk("lk_agnt", a_gnt, 1);
      chk("lk_bgnt", b_gnt, 0);
      @(negedge clk);
      chk("lk_locka", lock_a, (i < 3));
    end
    drv_a(0, 0, 0, 8'h00, 8'h00);
    #1 chk("lk_bgnt_rel", b_gnt, 1);
    @(negedge clk);
    chk("lk_brv", b_rvalid, 1);
    chk("lk_bdata", b_rdata, 8'hA2);

    // owner idles holding the lock
    drv_b(1, 0, 0, 8'h40, 8'h00);
    drv_a(1, 1, 1, 8'h40, 8'h77);
    #1 chk("id_agnt", a_gnt, 1);
    @(negedge clk);
    drv_a(0, 0, 1, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      #1 chk("id_bstall", b_gnt, 0);
      chk("id_locka", lock_a, 1);
      @(negedge clk);
    end
    drv_a(0, 0, 0, 8'h00, 8'h00);
    #1 chk("id_bgnt_same", b_gnt, 0);
    @(negedge clk);
    chk("id_unlock", lock_a, 0);
    #1 chk("id_bgnt_next", b_gnt, 1);
    @(negedge clk);
    chk("id_brv", b_rvalid, 1);
    chk("id_bdata", b_rdata, 8'h77);
    drv_b(0, 0, 0, 8'h00, 8'h00);

    // top address and aliasing
    drv_a(1, 1, 0, 8'hFF, 8'hFF);
    #1 chk("ff_gnt0", a_gnt, 1);
    @(negedge clk);
    drv_a(1, 1, 0, 8'hFF, 8'h00);
    @(negedge clk);
    drv_a(1, 0, 0, 8'hFF, 8'h00);
    @(negedge clk);
    drv_a(1, 0, 0, 8'h00, 8'h00);
    chk("ff_data", a_rdata, 8'h00);
    chk("ff_rv", a_rvalid, 1);
    @(negedge clk);
    chk("z_data", a_rdata, 8'hA0);
    chk("z_rv", a_rvalid, 1);

    // reset in the middle of a granted read
    drv_a(0, 0, 0, 8'h00, 8'h00);
    drv_b(1, 0, 1, 8'h10, 8'h00);
    #1 chk("rs_bgnt0", b_gnt, 1);
    @(negedge clk);
    chk("rs_lockb", lock_b, 1);
    chk("rs_brv0", b_rvalid, 1);
    chk("rs_bdata0", b_rdata, 8'h5A);
    #1 chk("rs_bgnt1", b_gnt, 1);
    #1 rst_n = 1'b0;
    #1 chk("rs_lockclr", lock_b, 0);
    chk("rs_rvclr", b_rvalid, 0);
    chk("rs_bdataclr", b_rdata, 0);
    @(posedge clk);
    #1 chk("rs_norv", b_rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drv_a(1, 0, 0, 8'h10, 8'h00);
    drv_b(1, 0, 0, 8'h20, 8'h00);
    #1 chk("rs_tie_a", a_gnt, 1);
    chk("rs_tie_b", b_gnt, 0);
    @(negedge clk);
    chk("rs_arv", a_rvalid, 1);
    chk("rs_adata", a_rdata, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
